// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall bit positions,
// canned stall vectors and the controller state encoding.
package pipe_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_MC   = 6'b001111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the sequencing controller (slave).
// All signals are level/cycle based: inputs are sampled every cycle, outputs apply at the next edge.
interface pipe_ctrl_if;
  logic        id_rd1_en;
  logic        id_rd2_en;
  logic [4:0]  id_addr1;
  logic [4:0]  id_addr2;
  logic        ex_wr_en;
  logic [4:0]  ex_wr_addr;
  logic        ex_is_load;
  logic        ex_mc_start;
  logic        br_flush_req;
  logic        lu_clr;
  logic [5:0]  stall;
  logic        flush;
  logic        mc_busy;
  logic        mc_done;
  logic [15:0] lu_count;
  logic [1:0]  state_dbg;

  modport master (
    output id_rd1_en, id_rd2_en, id_addr1, id_addr2,
           ex_wr_en, ex_wr_addr, ex_is_load, ex_mc_start,
           br_flush_req, lu_clr,
    input  stall, flush, mc_busy, mc_done, lu_count, state_dbg
  );

  modport slave (
    input  id_rd1_en, id_rd2_en, id_addr1, id_addr2,
           ex_wr_en, ex_wr_addr, ex_is_load, ex_mc_start,
           br_flush_req, lu_clr,
    output stall, flush, mc_busy, mc_done, lu_count, state_dbg
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard check: a load in EX whose destination is read by decode.
// Register 0 is hardwired and never creates a dependency.
module hazard_detect (
  input  logic       rd1_en,
  input  logic       rd2_en,
  input  logic [4:0] addr1,
  input  logic [4:0] addr2,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic       is_load,
  output logic       lu
);
  logic match1;
  logic match2;

  assign match1 = rd1_en && (addr1 == wr_addr);
  assign match2 = rd2_en && (addr2 == wr_addr);
  assign lu     = is_load && wr_en && (wr_addr != 5'd0) && (match1 || match2);
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage core: flush beats multi-cycle EX beats load-use.
// Also keeps a saturating count of applied load-use stall cycles.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic            clk,
  input  logic            reset,
  pipe_ctrl_if.slave      bus
);

  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_MC    = MC_BUSY;
  localparam logic [1:0] S_FLUSH = FLUSH;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      lu_count_q, lu_count_d;
  logic [5:0]       stall;
  logic             flush;
  logic             mc_done;
  logic             lu;
  logic             lu_apply;

  hazard_detect u_hazard (
    .rd1_en  (bus.id_rd1_en),
    .rd2_en  (bus.id_rd2_en),
    .addr1   (bus.id_addr1),
    .addr2   (bus.id_addr2),
    .wr_en   (bus.ex_wr_en),
    .wr_addr (bus.ex_wr_addr),
    .is_load (bus.ex_is_load),
    .lu      (lu)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    stall    = STALL_NONE;
    flush    = 1'b0;
    mc_done  = 1'b0;
    lu_apply = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.br_flush_req) begin
          flush   = 1'b1;
          state_d = S_FLUSH;
        end else if (bus.ex_mc_start) begin
          stall   = STALL_MC;
          count_d = CNT_W'(MC_CYCLES - 1);
          state_d = S_MC;
        end else if (lu) begin
          stall    = STALL_LU;
          lu_apply = 1'b1;
        end
      end
      S_MC: begin
        // A redirect kills the op in flight, so no completion pulse follows.
        if (bus.br_flush_req) begin
          flush   = 1'b1;
          count_d = '0;
          state_d = S_FLUSH;
        end else if (count_q == CNT_W'(1)) begin
          mc_done = 1'b1;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          stall   = STALL_MC;
          count_d = count_q - CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (bus.br_flush_req) flush = 1'b1;
        else                  state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    lu_count_d = lu_count_q;
    if (bus.lu_clr)                               lu_count_d = '0;
    else if (lu_apply && lu_count_q != 16'hFFFF)  lu_count_d = lu_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      count_q    <= '0;
      lu_count_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lu_count_q <= lu_count_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.mc_done   = mc_done;
  assign bus.mc_busy   = (state_q == S_MC);
  assign bus.lu_count  = lu_count_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;
  localparam int MC = 4;

  typedef struct {
    logic       rd1_en;
    logic       rd2_en;
    logic [4:0] a1;
    logic [4:0] a2;
    logic       wr_en;
    logic [4:0] wa;
    logic       is_load;
    logic       mc_start;
    logic       br;
    logic       clr;
  } stim_t;

  // Expected word: {stall[5:0], flush, mc_done, mc_busy, lu_count[15:0]}
  logic [24:0] exp_q[$];

  logic clk;
  logic reset;
  logic sb_en;
  int   vectors;
  int   miscompares;

  // Reference model: operating mode, age of the running multi-cycle op, perf count
  localparam int M_RUN = 0;
  localparam int M_MC  = 1;
  localparam int M_FL  = 2;
  int m_mode;
  int m_age;
  int m_lu;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MC_CYCLES(MC), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rd1_en = 0; s.rd2_en = 0; s.a1 = 0; s.a2 = 0; s.wr_en = 0; s.wa = 0;
    s.is_load = 0; s.mc_start = 0; s.br = 0; s.clr = 0;
    return s;
  endfunction

  function automatic stim_t lu_stim(input logic [4:0] addr);
    stim_t s;
    s = idle_stim();
    s.is_load = 1; s.wr_en = 1; s.wa = addr; s.rd2_en = 1; s.a2 = addr;
    return s;
  endfunction

  function automatic void model_reset();
    m_mode = M_RUN;
    m_age  = 0;
    m_lu   = 0;
  endfunction

  // One cycle of behaviour: returns the outputs for this cycle, then advances the model.
  function automatic logic [24:0] model_step(input stim_t s);
    logic [5:0] st;
    logic fl, done, busy, hz, applied;
    logic [15:0] cnt;
    st = 6'b000000; fl = 0; done = 0; applied = 0;
    busy = (m_mode == M_MC);
    cnt  = 16'(m_lu);
    hz = s.is_load && s.wr_en && (s.wa != 0) &&
         ((s.rd1_en && s.a1 == s.wa) || (s.rd2_en && s.a2 == s.wa));
    if (m_mode == M_RUN) begin
      if (s.br) begin
        fl = 1; m_mode = M_FL;
      end else if (s.mc_start) begin
        st = 6'b001111; m_mode = M_MC; m_age = 1;
      end else if (hz) begin
        st = 6'b000111; applied = 1;
      end
    end else if (m_mode == M_MC) begin
      if (s.br) begin
        fl = 1; m_mode = M_FL;
      end else if (m_age == MC - 1) begin
        done = 1; m_mode = M_RUN;
      end else begin
        st = 6'b001111; m_age = m_age + 1;
      end
    end else begin
      if (s.br) fl = 1;
      else      m_mode = M_RUN;
    end
    if (s.clr)                         m_lu = 0;
    else if (applied && m_lu < 65535)  m_lu = m_lu + 1;
    return {st, fl, done, busy, cnt};
  endfunction

  task automatic apply(input stim_t s);
    bus.id_rd1_en    = s.rd1_en;
    bus.id_rd2_en    = s.rd2_en;
    bus.id_addr1     = s.a1;
    bus.id_addr2     = s.a2;
    bus.ex_wr_en     = s.wr_en;
    bus.ex_wr_addr   = s.wa;
    bus.ex_is_load   = s.is_load;
    bus.ex_mc_start  = s.mc_start;
    bus.br_flush_req = s.br;
    bus.lu_clr       = s.clr;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    exp_q.push_back(model_step(s));
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (bus.stall !== 6'b0 || bus.flush !== 1'b0 || bus.mc_busy !== 1'b0 ||
        bus.mc_done !== 1'b0 || bus.lu_count !== 16'h0) begin
      miscompares++;
      $display("FAIL %s: stall=%b flush=%b mc_busy=%b mc_done=%b lu_count=%h, required all zero",
               name, bus.stall, bus.flush, bus.mc_busy, bus.mc_done, bus.lu_count);
    end
  endtask

  // Monitor: outputs are combinational on the inputs driven just after posedge
  always @(negedge clk) begin
    if (sb_en && exp_q.size() > 0) begin
      logic [24:0] exp_w, act_w;
      exp_w = exp_q.pop_front();
      act_w = {bus.stall, bus.flush, bus.mc_done, bus.mc_busy, bus.lu_count};
      vectors++;
      if (act_w !== exp_w) begin
        miscompares++;
        $display("FAIL cycle @%0t: got stall=%b flush=%b done=%b busy=%b lu=%h, required stall=%b flush=%b done=%b busy=%b lu=%h",
                 $time, act_w[24:19], act_w[18], act_w[17], act_w[16], act_w[15:0],
                 exp_w[24:19], exp_w[18], exp_w[17], exp_w[16], exp_w[15:0]);
      end
    end
  end

  // Multi-cycle start is only legal while the pipeline is running normally
  always @(negedge clk) begin
    if (sb_en && bus.ex_mc_start === 1'b1)
      assert (m_mode == M_RUN || bus.br_flush_req === 1'b1 || bus.mc_busy === 1'b0)
        else $error("ex_mc_start outside RUN");
  end

  initial begin
    stim_t s;
    vectors = 0;
    miscompares = 0;
    sb_en = 0;
    model_reset();
    apply(idle_stim());
    reset = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1;
    sb_en = 1;

    // Load-use on port 2, then the same pattern against r0
    drive(lu_stim(5'd5));
    drive(idle_stim());
    drive(lu_stim(5'd0));
    drive(idle_stim());
    s = idle_stim(); s.is_load = 1; s.wr_en = 1; s.wa = 5'd9; s.rd1_en = 1; s.a1 = 5'd9;
    drive(s);
    drive(idle_stim());

    // Full multi-cycle op
    s = idle_stim(); s.mc_start = 1;
    drive(s);
    repeat (4) drive(idle_stim());

    // Multi-cycle op aborted by a redirect one cycle in
    s = idle_stim(); s.mc_start = 1;
    drive(s);
    s = idle_stim(); s.br = 1;
    drive(s);
    repeat (3) drive(idle_stim());

    // Everything at once in RUN, then hazard held through FLUSH
    s = lu_stim(5'd7); s.mc_start = 1; s.br = 1;
    drive(s);
    drive(lu_stim(5'd7));
    drive(lu_stim(5'd7));
    // Back-to-back redirects stay in FLUSH
    s = idle_stim(); s.br = 1;
    drive(s);
    drive(s);
    drive(idle_stim());

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      s.rd1_en   = ($urandom_range(0, 1) == 1);
      s.rd2_en   = ($urandom_range(0, 1) == 1);
      s.a1       = 5'($urandom_range(0, 3));
      s.a2       = 5'($urandom_range(0, 3));
      s.wa       = 5'($urandom_range(0, 3));
      s.wr_en    = ($urandom_range(0, 3) != 0);
      s.is_load  = ($urandom_range(0, 1) == 1);
      s.br       = ($urandom_range(0, 15) == 0);
      s.clr      = ($urandom_range(0, 31) == 0);
      s.mc_start = (m_mode == M_RUN) && ($urandom_range(0, 19) == 0);
      drive(s);
    end
    drive(idle_stim());

    // Saturation then clear with the hazard still present
    s = idle_stim(); s.clr = 1;
    drive(s);
    for (int i = 0; i < 65537; i++) drive(lu_stim(5'd3));
    s = lu_stim(5'd3); s.clr = 1;
    drive(s);
    drive(lu_stim(5'd3));
    drive(idle_stim());

    // Asynchronous reset in the middle of a multi-cycle op
    s = idle_stim(); s.mc_start = 1;
    drive(s);
    @(posedge clk);
    #1;
    sb_en = 0;
    apply(idle_stim());
    reset = 0;
    #1 check_reset_outputs("reset_mid_mc");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1;
    sb_en = 1;
    drive(idle_stim());
    drive(lu_stim(5'd12));
    drive(idle_stim());
    s = idle_stim(); s.mc_start = 1;
    drive(s);
    repeat (4) drive(idle_stim());

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
